// File: rtl/sad_accum_4b_pkg.sv
// rtl/sad_accum_4b_pkg.sv - shared widths, state encoding and helpers for the SAD accumulator
//
// Purpose : common definitions imported by sad_accum_4b and sad_block_counter.
// Contents: SAD_SUM_W / SAD_DIFF_W / SAD_CNT_W widths, the two-state encoding
//           (STATE_ACCUM=0, STATE_DONE=1) and a zero-extension helper for diffs.
package sad_accum_4b_pkg;

    localparam int SAD_SUM_W       = 8;
    localparam int SAD_DIFF_W      = 4;
    localparam int SAD_CNT_W       = 5;
    localparam int SAD_MAX_SAMPLES = 16;

    typedef enum logic {
        STATE_ACCUM = 1'b0,
        STATE_DONE  = 1'b1
    } sad_state_t;

    // Diffs are unsigned, so widening to the accumulator width is a plain zero-extend.
    function automatic logic [SAD_SUM_W-1:0] sad_zext_diff(input logic [SAD_DIFF_W-1:0] i_diff);
        return {{(SAD_SUM_W-SAD_DIFF_W){1'b0}}, i_diff};
    endfunction

endpackage

// File: rtl/sad_block_counter.sv
// rtl/sad_block_counter.sv - per-block sample counter with clear, increment and last-sample flag
//
// Purpose : counts samples accepted into the current SAD block.
// Ports   : clk     - clock, rising edge
//           rst     - asynchronous active-high reset (count -> 0)
//           i_clr   - synchronous clear, wins over i_inc
//           i_inc   - increment enable
//           o_count - current count (SAD_CNT_W bits)
//           o_last  - high when o_count == NSAMPLES-1, i.e. the next sample closes the block
module sad_block_counter
    import sad_accum_4b_pkg::*;
#(
    parameter int NSAMPLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clr,
    input  logic                 i_inc,
    output logic [SAD_CNT_W-1:0] o_count,
    output logic                 o_last
);

    generate
        if (NSAMPLES < 1 || NSAMPLES > SAD_MAX_SAMPLES) begin : g_bad_nsamples
            $error("sad_block_counter: NSAMPLES must be in 1..16");
        end
    endgenerate

    localparam logic [SAD_CNT_W-1:0] LAST_COUNT = SAD_CNT_W'(NSAMPLES - 1);

    logic [SAD_CNT_W-1:0] r_count;
    logic [SAD_CNT_W-1:0] w_count_d;

    // Expressed as a mux chain so an X on the enables shows up as X in the count.
    assign w_count_d = i_clr ? '0 : (i_inc ? (r_count + SAD_CNT_W'(1)) : r_count);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_d;
        end
    end

    assign o_count = r_count;
    assign o_last  = (r_count == LAST_COUNT);

endmodule

// File: rtl/sad_accum_4b.sv
// rtl/sad_accum_4b.sv - sequential sum-of-absolute-differences accumulator over NSAMPLES 4-bit diffs
//
// Purpose : accepts 4-bit |a-b| samples on a val/rdy input, sums NSAMPLES of them into
//           an 8-bit block sum and presents it on a val/rdy output until accepted.
// Ports   : clk       - clock, rising edge
//           rst       - asynchronous active-high reset; drops any partial block
//           in_val    - in_diff valid
//           in_rdy    - high in ACCUM, low in DONE (state-only, no path from in_val)
//           in_diff   - unsigned 4-bit absolute difference
//           out_val   - high in DONE (state-only, no path from out_rdy)
//           out_rdy   - consumer accepts out_sum
//           out_sum   - accumulator register, valid when out_val
//           out_count - samples accepted into the current block
module sad_accum_4b
    import sad_accum_4b_pkg::*;
#(
    parameter int NSAMPLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_val,
    output logic                  in_rdy,
    input  logic [SAD_DIFF_W-1:0] in_diff,
    output logic                  out_val,
    input  logic                  out_rdy,
    output logic [SAD_SUM_W-1:0]  out_sum,
    output logic [SAD_CNT_W-1:0]  out_count
);

    generate
        if (NSAMPLES < 1 || NSAMPLES > SAD_MAX_SAMPLES) begin : g_bad_nsamples
            $error("sad_accum_4b: NSAMPLES must be in 1..16");
        end
    endgenerate

    sad_state_t           r_state;
    sad_state_t           w_state_nxt;
    logic [SAD_SUM_W-1:0] r_sum;
    logic [SAD_SUM_W-1:0] w_sum_add;
    logic [SAD_SUM_W-1:0] w_sum_d;
    logic                 w_in_xfer;
    logic                 w_out_xfer;
    logic                 w_last;
    logic [SAD_CNT_W-1:0] w_count;

    // Transfers are qualified by state directly rather than by in_rdy/out_val so the
    // handshake terms do not loop back through the output decode below.
    assign w_in_xfer  = in_val  & (r_state == STATE_ACCUM);
    assign w_out_xfer = out_rdy & (r_state == STATE_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= STATE_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_rdy      = 1'b0;
        out_val     = 1'b0;
        case (r_state)
            STATE_ACCUM: begin
                in_rdy = 1'b1;
                if (in_val && w_last) begin
                    w_state_nxt = STATE_DONE;
                end
            end
            STATE_DONE: begin
                out_val = 1'b1;
                if (out_rdy) begin
                    w_state_nxt = STATE_ACCUM;
                end
            end
            default: begin
                w_state_nxt = STATE_ACCUM;
            end
        endcase
    end

    sad_block_counter #(
        .NSAMPLES (NSAMPLES)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_out_xfer),
        .i_inc   (w_in_xfer),
        .o_count (w_count),
        .o_last  (w_last)
    );

    // 16 * 15 = 240 fits in 8 bits, so the adder carries no overflow handling.
    assign w_sum_add = r_sum + sad_zext_diff(in_diff);

    // Ternary chain rather than if/else: an X on in_val or in_diff during a
    // transfer lands in r_sum as X instead of being silently treated as "no transfer".
    assign w_sum_d = w_out_xfer ? '0 : (w_in_xfer ? w_sum_add : r_sum);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
        end else begin
            r_sum <= w_sum_d;
        end
    end

    assign out_sum   = r_sum;
    assign out_count = w_count;

endmodule

// File: tb/tb_sad_accum_4b.sv
// tb/tb_sad_accum_4b.sv - scenario testbench for sad_accum_4b (NSAMPLES = 4, 16, 1)
module tb_sad_accum_4b;

    logic            clk;
    logic            rst;
    logic [2:0]      in_val;
    logic [2:0]      in_rdy;
    logic [2:0][3:0] in_diff;
    logic [2:0]      out_val;
    logic [2:0]      out_rdy;
    logic [2:0][7:0] out_sum;
    logic [2:0][4:0] out_count;

    int n_checks;
    int n_pass;
    logic [7:0] exp_q[$];

    // instance 0: NSAMPLES=4, instance 1: NSAMPLES=16, instance 2: NSAMPLES=1
    sad_accum_4b #(.NSAMPLES(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_val(in_val[0]), .in_rdy(in_rdy[0]), .in_diff(in_diff[0]),
        .out_val(out_val[0]), .out_rdy(out_rdy[0]), .out_sum(out_sum[0]), .out_count(out_count[0]));
    sad_accum_4b #(.NSAMPLES(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_val(in_val[1]), .in_rdy(in_rdy[1]), .in_diff(in_diff[1]),
        .out_val(out_val[1]), .out_rdy(out_rdy[1]), .out_sum(out_sum[1]), .out_count(out_count[1]));
    sad_accum_4b #(.NSAMPLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_val(in_val[2]), .in_rdy(in_rdy[2]), .in_diff(in_diff[2]),
        .out_val(out_val[2]), .out_rdy(out_rdy[2]), .out_sum(out_sum[2]), .out_count(out_count[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] absdiff4(input logic [3:0] a, input logic [3:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Present one sample after `gap` idle cycles and hold it until accepted.
    task automatic send(input int k, input logic [3:0] d, input int gap);
        int b;
        in_val[k] = 1'b0;
        repeat (gap) step();
        in_val[k]  = 1'b1;
        in_diff[k] = d;
        b = 0;
        while (in_rdy[k] !== 1'b1 && b < 50) begin
            step();
            b++;
        end
        if (b == 50) begin
            n_checks++;
            $display("FAIL send_timeout inst=%0d in_rdy=%b required 1", k, in_rdy[k]);
        end
        step();
        in_val[k] = 1'b0;
    endtask

    // Wait for out_val, capture the result, then complete the output handshake.
    task automatic wait_out(input int k, output bit ok, output logic [7:0] s, output logic [4:0] c);
        int b;
        b  = 0;
        ok = 1'b0;
        s  = '0;
        c  = '0;
        while (out_val[k] !== 1'b1 && b < 200) begin
            step();
            b++;
        end
        if (out_val[k] === 1'b1) begin
            ok = 1'b1;
            s  = out_sum[k];
            c  = out_count[k];
            out_rdy[k] = 1'b1;
            step();
        end
    endtask

    function automatic logic [7:0] pop_exp();
        if (exp_q.size() == 0) return 8'hxx;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset();
        rst     = 1'b1;
        in_val  = '0;
        in_diff = '0;
        out_rdy = '0;
        exp_q.delete();
        repeat (2) step();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (out_val[k] !== 1'b0) $display("FAIL reset_out_val inst=%0d got %b required 0", k, out_val[k]);
            else n_pass++;
            n_checks++;
            if (in_rdy[k] !== 1'b1) $display("FAIL reset_in_rdy inst=%0d got %b required 1", k, in_rdy[k]);
            else n_pass++;
            n_checks++;
            if (out_sum[k] !== 8'd0 || out_count[k] !== 5'd0)
                $display("FAIL reset_sum_count inst=%0d got sum=%0d count=%0d required 0/0", k, out_sum[k], out_count[k]);
            else n_pass++;
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [3:0] d[4] = '{4'd3, 4'd5, 4'd0, 4'd15};
        logic [7:0] e;
        out_rdy[0] = 1'b1;
        exp_q.push_back(8'd23);
        for (int i = 0; i < 4; i++) begin
            in_val[0]  = 1'b1;
            in_diff[0] = d[i];
            n_checks++;
            if (out_val[0] !== 1'b0 || in_rdy[0] !== 1'b1)
                $display("FAIL basic_accum_state i=%0d got out_val=%b in_rdy=%b required 0/1", i, out_val[0], in_rdy[0]);
            else n_pass++;
            step();
        end
        in_val[0] = 1'b0;
        e = pop_exp();
        n_checks++;
        if (out_val[0] !== 1'b1 || in_rdy[0] !== 1'b0)
            $display("FAIL basic_done_latency got out_val=%b in_rdy=%b required 1/0", out_val[0], in_rdy[0]);
        else n_pass++;
        n_checks++;
        if (out_sum[0] !== e) $display("FAIL basic_sum got %0d required %0d", out_sum[0], e);
        else n_pass++;
        n_checks++;
        if (out_count[0] !== 5'd4) $display("FAIL basic_count got %0d required 4", out_count[0]);
        else n_pass++;
        step();
        n_checks++;
        if (in_rdy[0] !== 1'b1 || out_val[0] !== 1'b0 || out_sum[0] !== 8'd0 || out_count[0] !== 5'd0)
            $display("FAIL basic_restart got in_rdy=%b out_val=%b sum=%0d count=%0d required 1/0/0/0",
                     in_rdy[0], out_val[0], out_sum[0], out_count[0]);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [3:0] d[4] = '{4'd3, 4'd5, 4'd0, 4'd15};
        bit ok;
        logic [7:0] s;
        logic [4:0] c;
        logic [7:0] e;
        out_rdy[0] = 1'b0;
        for (int i = 0; i < 4; i++) send(0, d[i], 0);
        n_checks++;
        if (out_val[0] !== 1'b1) $display("FAIL bp_done got out_val=%b required 1", out_val[0]);
        else n_pass++;
        in_val[0]  = 1'b1;
        in_diff[0] = 4'd9;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (out_val[0] !== 1'b1 || in_rdy[0] !== 1'b0 || out_sum[0] !== 8'd23 || out_count[0] !== 5'd4)
                $display("FAIL bp_hold cyc=%0d got val=%b rdy=%b sum=%0d count=%0d required 1/0/23/4",
                         i, out_val[0], in_rdy[0], out_sum[0], out_count[0]);
            else n_pass++;
        end
        out_rdy[0] = 1'b1;
        step();
        n_checks++;
        if (out_val[0] !== 1'b0 || out_sum[0] !== 8'd0 || out_count[0] !== 5'd0)
            $display("FAIL bp_release got val=%b sum=%0d count=%0d required 0/0/0", out_val[0], out_sum[0], out_count[0]);
        else n_pass++;
        step();
        in_val[0] = 1'b0;
        n_checks++;
        if (out_sum[0] !== 8'd9 || out_count[0] !== 5'd1)
            $display("FAIL bp_first_sample got sum=%0d count=%0d required 9/1", out_sum[0], out_count[0]);
        else n_pass++;
        exp_q.push_back(8'd12);
        out_rdy[0] = 1'b0;
        for (int i = 0; i < 3; i++) send(0, 4'd1, i);
        wait_out(0, ok, s, c);
        e = pop_exp();
        n_checks++;
        if (!ok || s !== e) $display("FAIL bp_next_block got ok=%0d sum=%0d required %0d", ok, s, e);
        else n_pass++;
    endtask

    task automatic test_max_block();
        bit ok;
        logic [7:0] s;
        logic [4:0] c;
        logic [7:0] e;
        out_rdy[1] = 1'b0;
        exp_q.push_back(8'd240);
        for (int i = 0; i < 16; i++) send(1, 4'd15, $urandom_range(0, 3));
        wait_out(1, ok, s, c);
        e = pop_exp();
        n_checks++;
        if (!ok || s !== e) $display("FAIL max_sum got ok=%0d sum=%0d required %0d", ok, s, e);
        else n_pass++;
        n_checks++;
        if (c !== 5'd16) $display("FAIL max_count got %0d required 16", c);
        else n_pass++;
    endtask

    task automatic test_reset_mid_block();
        bit ok;
        logic [7:0] s;
        logic [4:0] c;
        logic [7:0] e;
        out_rdy[0] = 1'b0;
        send(0, 4'd7, 0);
        send(0, 4'd7, 0);
        n_checks++;
        if (out_count[0] !== 5'd2 || out_sum[0] !== 8'd14)
            $display("FAIL midrst_partial got count=%0d sum=%0d required 2/14", out_count[0], out_sum[0]);
        else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_val[0] !== 1'b0 || in_rdy[0] !== 1'b1 || out_count[0] !== 5'd0 || out_sum[0] !== 8'd0)
            $display("FAIL midrst_async got val=%b rdy=%b count=%0d sum=%0d required 0/1/0/0",
                     out_val[0], in_rdy[0], out_count[0], out_sum[0]);
        else n_pass++;
        step();
        rst = 1'b0;
        step();
        exp_q.delete();
        exp_q.push_back(8'd4);
        for (int i = 0; i < 4; i++) send(0, 4'd1, 0);
        wait_out(0, ok, s, c);
        e = pop_exp();
        n_checks++;
        if (!ok || s !== e) $display("FAIL midrst_block got ok=%0d sum=%0d required %0d", ok, s, e);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] d[3] = '{4'd2, 4'd4, 4'd6};
        logic [7:0] e;
        out_rdy[2] = 1'b1;
        in_val[2]  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_diff[2] = d[i];
            exp_q.push_back({4'd0, d[i]});
            step();
            e = pop_exp();
            n_checks++;
            if (out_val[2] !== 1'b1 || in_rdy[2] !== 1'b0 || out_sum[2] !== e)
                $display("FAIL b2b_emit i=%0d got val=%b rdy=%b sum=%0d required 1/0/%0d",
                         i, out_val[2], in_rdy[2], out_sum[2], e);
            else n_pass++;
            step();
            n_checks++;
            if (out_val[2] !== 1'b0 || in_rdy[2] !== 1'b1)
                $display("FAIL b2b_bubble i=%0d got val=%b rdy=%b required 0/1", i, out_val[2], in_rdy[2]);
            else n_pass++;
        end
        in_val[2] = 1'b0;
    endtask

    task automatic test_upstream();
        logic [3:0] a[4] = '{4'd3, 4'd10, 4'd0, 4'd8};
        logic [3:0] b[4] = '{4'd10, 4'd3, 4'd15, 4'd8};
        bit ok;
        logic [7:0] s;
        logic [4:0] c;
        logic [7:0] e;
        out_rdy[0] = 1'b0;
        exp_q.push_back(8'd29);
        for (int i = 0; i < 4; i++) send(0, absdiff4(a[i], b[i]), 1);
        wait_out(0, ok, s, c);
        e = pop_exp();
        n_checks++;
        if (!ok || s !== e) $display("FAIL upstream_sum got ok=%0d sum=%0d required %0d", ok, s, e);
        else n_pass++;
    endtask

    task automatic test_random_blocks();
        bit ok;
        logic [7:0] s;
        logic [4:0] c;
        logic [7:0] e;
        logic [7:0] acc;
        logic [3:0] d;
        for (int blk = 0; blk < 4; blk++) begin
            out_rdy[0] = 1'b0;
            acc = '0;
            for (int i = 0; i < 4; i++) begin
                d   = 4'($urandom_range(0, 15));
                acc = acc + {4'd0, d};
                send(0, d, $urandom_range(0, 2));
            end
            exp_q.push_back(acc);
            repeat ($urandom_range(0, 3)) step();
            wait_out(0, ok, s, c);
            e = pop_exp();
            n_checks++;
            if (!ok || s !== e || c !== 5'd4)
                $display("FAIL rand_block blk=%0d got ok=%0d sum=%0d count=%0d required %0d/4", blk, ok, s, c, e);
            else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_max_block();
        test_reset_mid_block();
        test_back_to_back();
        test_upstream();
        test_random_blocks();
        repeat (2) step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
